// File: rtl/dpseq_pkg.sv
// Shared types for the datapath sequencer: opcodes, FSM states, command bundle.
// Command widths here set the default DATA_W / ADDR_W of the top.
package dpseq_pkg;

  localparam int DPSEQ_DATA_W = 16;
  localparam int DPSEQ_ADDR_W = 3;
  localparam int FIFO_DEPTH   = 4;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOADI = 2'b10,
    OP_MOVE  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE
  } state_e;

  typedef struct packed {
    op_e                     op;
    logic [DPSEQ_ADDR_W-1:0] rd;
    logic [DPSEQ_ADDR_W-1:0] rs1;
    logic [DPSEQ_ADDR_W-1:0] rs2;
    logic [DPSEQ_DATA_W-1:0] imm;
  } cmd_t;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dpseq_cmd_fifo.sv
// Small synchronous command FIFO for the datapath sequencer.
// Head entry is presented combinationally on rdata while not empty.
module dpseq_cmd_fifo
  import dpseq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  cmd_t wdata,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  cmd_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(FIFO_DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      if (do_push && !do_pop)
        cnt <= cnt + CW'(1);
      else if (do_pop && !do_push)
        cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/datapath_seq_ctrl.sv
// Sequencer driving an external regfile and adder: READ -> EXEC -> WRITE.
// Define DPSEQ_CMD_FIFO_EN for a 4-entry command FIFO in front of the FSM.
module datapath_seq_ctrl
  import dpseq_pkg::*;
#(
  parameter int DATA_W = DPSEQ_DATA_W,
  parameter int ADDR_W = DPSEQ_ADDR_W
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] rf_ra_addr,
  output logic [ADDR_W-1:0] rf_rb_addr,
  input  logic [DATA_W-1:0] rf_ra_data,
  input  logic [DATA_W-1:0] rf_rb_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_sub,
  input  logic [DATA_W-1:0] alu_sum,
  input  logic              alu_cout,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              busy,
  output logic              done_pulse,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic [15:0]       op_count
);

  state_e            state;
  op_e               cur_op;
  logic [ADDR_W-1:0] cur_rd;
  cmd_t              incoming;
  cmd_t              start_cmd;
  logic              accept;
  logic              start;

  assign incoming = '{
    op:  op_e'(cmd_op),
    rd:  cmd_rd,
    rs1: cmd_rs1,
    rs2: cmd_rs2,
    imm: cmd_imm
  };

`ifdef DPSEQ_CMD_FIFO_EN
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic bypass;
  cmd_t head;

  // An idle FSM with nothing queued takes the command directly.
  assign cmd_ready = !full && !wb_rst_i;
  assign accept    = cmd_valid && cmd_ready;
  assign pop       = (state == S_IDLE) && !empty;
  assign bypass    = accept && (state == S_IDLE) && empty;
  assign push      = accept && !bypass;
  assign start     = pop || bypass;
  assign start_cmd = pop ? head : incoming;
  assign busy      = (state != S_IDLE) || !empty;

  dpseq_cmd_fifo u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push),
    .pop   (pop),
    .wdata (incoming),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
`else
  assign cmd_ready = (state == S_IDLE) && !wb_rst_i;
  assign accept    = cmd_valid && cmd_ready;
  assign start     = accept;
  assign start_cmd = incoming;
  assign busy      = (state != S_IDLE);
`endif

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sub = 1'b0;
    if (state == S_EXEC) begin
      alu_a   = rf_ra_data;
      alu_b   = (cur_op == OP_MOVE) ? '0 : rf_rb_data;
      alu_sub = (cur_op == OP_SUB);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= S_IDLE;
      cur_op     <= OP_ADD;
      cur_rd     <= '0;
      rf_ra_addr <= '0;
      rf_rb_addr <= '0;
      rf_we      <= 1'b0;
      rf_wa      <= '0;
      rf_wd      <= '0;
      done_pulse <= 1'b0;
      result     <= '0;
      carry      <= 1'b0;
      op_count   <= '0;
    end else begin
      rf_ra_addr <= '0;
      rf_rb_addr <= '0;
      rf_we      <= 1'b0;
      rf_wa      <= '0;
      rf_wd      <= '0;
      done_pulse <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            cur_op <= start_cmd.op;
            cur_rd <= start_cmd.rd;
            if (start_cmd.op == OP_LOADI) begin
              state      <= S_WRITE;
              rf_we      <= 1'b1;
              rf_wa      <= start_cmd.rd;
              rf_wd      <= start_cmd.imm;
              done_pulse <= 1'b1;
              result     <= start_cmd.imm;
              carry      <= 1'b0;
            end else begin
              state      <= S_READ;
              rf_ra_addr <= start_cmd.rs1;
              rf_rb_addr <= start_cmd.rs2;
            end
          end
        end
        S_READ: begin
          state <= S_EXEC;
        end
        S_EXEC: begin
          state      <= S_WRITE;
          result     <= alu_sum;
          carry      <= alu_cout;
          rf_we      <= 1'b1;
          rf_wa      <= cur_rd;
          rf_wd      <= alu_sum;
          done_pulse <= 1'b1;
        end
        S_WRITE: begin
          state    <= S_IDLE;
          op_count <= sat_inc(op_count);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// Bench for datapath_seq_ctrl: regfile/adder environment plus a
// command-level model of expected regfile writes, latency and counts.
`timescale 1ns/1ps
module tb_datapath_seq_ctrl;

  localparam logic [1:0] ADD   = 2'b00;
  localparam logic [1:0] SUB   = 2'b01;
  localparam logic [1:0] LOADI = 2'b10;
  localparam logic [1:0] MOVE  = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [2:0]  cmd_rd = '0;
  logic [2:0]  cmd_rs1 = '0;
  logic [2:0]  cmd_rs2 = '0;
  logic [15:0] cmd_imm = '0;
  logic [2:0]  rf_ra_addr;
  logic [2:0]  rf_rb_addr;
  logic [15:0] rf_ra_data = '0;
  logic [15:0] rf_rb_data = '0;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_sub;
  logic [15:0] alu_sum;
  logic        alu_cout;
  logic        rf_we;
  logic [2:0]  rf_wa;
  logic [15:0] rf_wd;
  logic        busy;
  logic        done_pulse;
  logic [15:0] result;
  logic        carry;
  logic [15:0] op_count;

  datapath_seq_ctrl dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .cmd_imm    (cmd_imm),
    .rf_ra_addr (rf_ra_addr),
    .rf_rb_addr (rf_rb_addr),
    .rf_ra_data (rf_ra_data),
    .rf_rb_data (rf_rb_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sub    (alu_sub),
    .alu_sum    (alu_sum),
    .alu_cout   (alu_cout),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .busy       (busy),
    .done_pulse (done_pulse),
    .result     (result),
    .carry      (carry),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  // Environment: registered-read regfile and combinational adder.
  logic [15:0] rf_mem [8] = '{default: 16'h0};
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_wa] <= rf_wd;
    rf_ra_data <= rf_mem[rf_ra_addr];
    rf_rb_data <= rf_mem[rf_rb_addr];
  end
  assign {alu_cout, alu_sum} = {1'b0, alu_a}
    + {1'b0, (alu_sub ? ~alu_b : alu_b)}
    + {16'h0, alu_sub};

  typedef struct {
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        c;
    int          cyc;
    bit          direct;
  } exp_t;

  exp_t        q [$];
  logic [15:0] mregs [8] = '{default: 16'h0};
  int          mcount = 0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic void model(input logic [1:0] op,
                                input logic [2:0] rs1,
                                input logic [2:0] rs2,
                                input logic [15:0] imm,
                                output logic [15:0] wd,
                                output logic c);
    int unsigned a;
    int unsigned b;
    a = mregs[rs1];
    b = mregs[rs2];
    case (op)
      ADD:     begin wd = 16'(a + b); c = (a + b) > 65535; end
      SUB:     begin wd = 16'(a - b); c = (a >= b); end
      LOADI:   begin wd = imm; c = 1'b0; end
      default: begin wd = 16'(a); c = 1'b0; end
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("op_count", op_count, mcount);
      chk("done_vs_we", done_pulse, rf_we);
      if (rf_we) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write wa=%0d wd=%h required=none",
                   rf_wa, rf_wd);
        end else begin
          e = q.pop_front();
          chk("wr_addr", rf_wa, e.wa);
          chk("wr_data", rf_wd, e.wd);
          chk("wr_carry", carry, e.c);
          chk("wr_result", result, e.wd);
          if (e.direct) chk("latency", cyc, e.cyc);
          if (mcount < 65535) mcount++;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op,
                       input logic [2:0] rd,
                       input logic [2:0] rs1,
                       input logic [2:0] rs2,
                       input logic [15:0] imm,
                       input bit expect_wr);
    int n;
    exp_t e;
    logic [15:0] wd;
    logic c;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout ready=%b required=1", cmd_ready);
    end else begin
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_rd = rd;
      cmd_rs1 = rs1;
      cmd_rs2 = rs2;
      cmd_imm = imm;
      if (expect_wr) begin
        model(op, rs1, rs2, imm, wd, c);
        mregs[rd] = wd;
        e.wa = rd;
        e.wd = wd;
        e.c = c;
        e.cyc = cyc + ((op == LOADI) ? 1 : 3);
        e.direct = !busy;
        q.push_back(e);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy || q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout busy=%b pending=%0d required=0/0",
               busy, q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_done", done_pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry, 0);
    chk("rst_opcnt", op_count, 0);
    chk("rst_ra", rf_ra_addr, 0);
    chk("rst_wa", rf_wa, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);

    issue(LOADI, 3'd1, 3'd0, 3'd0, 16'h0005, 1);
    issue(LOADI, 3'd2, 3'd0, 3'd0, 16'h0003, 1);
    issue(ADD, 3'd3, 3'd1, 3'd2, 16'h0000, 1);
    wait_idle();
    chk("add_r3", rf_mem[3], 16'h0008);
    chk("add_res", result, 16'h0008);
    chk("add_carry", carry, 0);
    chk("add_opcnt", op_count, 3);

    issue(LOADI, 3'd1, 3'd0, 3'd0, 16'hFFFF, 1);
    issue(LOADI, 3'd2, 3'd0, 3'd0, 16'h0001, 1);
    issue(ADD, 3'd4, 3'd1, 3'd2, 16'h0000, 1);
    wait_idle();
    chk("wrap_r4", rf_mem[4], 16'h0000);
    chk("wrap_carry", carry, 1);

    issue(LOADI, 3'd1, 3'd0, 3'd0, 16'h0005, 1);
    issue(LOADI, 3'd2, 3'd0, 3'd0, 16'h0003, 1);
    issue(SUB, 3'd5, 3'd2, 3'd1, 16'h0000, 1);
    wait_idle();
    chk("sub_r5", rf_mem[5], 16'hFFFE);
    chk("sub_borrow", carry, 0);
    issue(MOVE, 3'd6, 3'd5, 3'd2, 16'h0000, 1);
    wait_idle();
    chk("move_r6", rf_mem[6], 16'hFFFE);

    issue(SUB, 3'd7, 3'd2, 3'd2, 16'h0000, 1);
    wait_idle();
    chk("sub_eq_r7", rf_mem[7], 16'h0000);
    chk("sub_noborrow", carry, 1);

    issue(LOADI, 3'd1, 3'd0, 3'd0, 16'h4000, 1);
    issue(ADD, 3'd1, 3'd1, 3'd1, 16'h0000, 1);
    wait_idle();
    chk("self_r1", rf_mem[1], 16'h8000);
    chk("total_opcnt", op_count, 13);

    // Abort an ADD with reset while it sits in EXEC.
    issue(ADD, 3'd3, 3'd1, 3'd1, 16'h0000, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_we", rf_we, 0);
    chk("abort_done", done_pulse, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 0);
    chk("abort_opcnt", op_count, 0);
    chk("abort_result", result, 0);
    repeat (2) @(negedge clk);
    mcount = 0;
    q.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_rel", cmd_ready, 1);
    chk("abort_idle", busy, 0);
    repeat (4) @(negedge clk);
    chk("abort_r3_kept", rf_mem[3], 16'h0008);

    issue(LOADI, 3'd2, 3'd0, 3'd0, 16'h0007, 1);
    issue(ADD, 3'd0, 3'd2, 3'd2, 16'h0000, 1);
    wait_idle();
    chk("recover_r0", rf_mem[0], 16'h000E);
    chk("recover_opcnt", op_count, 2);

`ifdef DPSEQ_CMD_FIFO_EN
    for (int i = 0; i < 6; i++)
      issue(ADD, 3'(i + 1), 3'(i), 3'd2, 16'h0000, 1);
    @(negedge clk);
    chk("fifo_full_ready", cmd_ready, 0);
    wait_idle();
    chk("fifo_opcnt", op_count, 8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
